zc_fetch_unit: RTL and testbench



---
 rtl/zc_fetch_unit_pkg.sv | 7 +
 rtl/zc_sync_fifo.sv | 46 ++++
 rtl/zc_fetch_unit.sv | 77 +++++++
 tb/tb_zc_fetch_unit.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/zc_fetch_unit_pkg.sv
// zc_fetch_unit_pkg: shared bus widths and default reset PC for the zerocore fetch path
package zc_fetch_unit_pkg;
  localparam int ADDR_BUS = 64;
  localparam int INST_BUS = 32;
  localparam int DATA_BUS = 64;
  localparam logic [63:0] RESET_PC_DEFAULT = 64'h8000_0000;
endpackage

// File: rtl/zc_sync_fifo.sv
// zc_sync_fifo: synchronous FIFO with flush, occupancy count and registered storage
module zc_sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [W-1:0]               i_data,
  input  logic                       i_pop,
  input  logic                       i_clear,
  output logic [W-1:0]               o_data,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0] r_count;
  logic w_push, w_pop;
  assign w_pop = i_pop & !o_empty;
  assign w_push = i_push & (!o_full | w_pop);
  assign o_data = r_mem[r_rd];
  assign o_count = r_count;
  assign o_full = r_count == (AW+1)'(DEPTH);
  assign o_empty = r_count == '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wr <= '0;
      r_rd <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr] <= i_data;
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
endmodule

// File: rtl/zc_fetch_unit.sv
// zc_fetch_unit: PC generation, RAM request tracking, lane select and instruction buffer
module zc_fetch_unit
  import zc_fetch_unit_pkg::*;
#(
  parameter int ADDR_W = ADDR_BUS,
  parameter int RAM_W = DATA_BUS,
  parameter int INST_W = INST_BUS,
  parameter int BUF_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              RamReadEnable,
  output logic [ADDR_W-1:0] RamReadAddr,
  input  logic [RAM_W-1:0]  RamReadData,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              fetch_misaligned
);
  localparam int LSB = $clog2(INST_W/8);
  localparam int LANES = RAM_W/INST_W;
  localparam int CW = $clog2(BUF_DEPTH) + 1;
  logic [ADDR_W-1:0] r_pc, r_req_addr;
  logic r_inflight, r_halt;
  logic [CW-1:0] w_count;
  logic [CW:0] w_credit;
  logic w_full, w_empty, w_pop, w_push;
  logic [INST_W-1:0] w_inst;
  assign w_pop = inst_valid & inst_ready;
  // entries held plus the response still owed must leave room for this request
  assign w_credit = {1'b0, w_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
  assign RamReadEnable = rst & !redirect_valid & !r_halt & (w_credit < (CW+1)'(BUF_DEPTH));
  assign RamReadAddr = r_pc;
  assign fetch_misaligned = r_halt;
  assign inst_valid = !w_empty;
  assign w_push = r_inflight & !redirect_valid;
  generate
    if (LANES > 1) begin : g_lane
      logic [$clog2(LANES)-1:0] w_lane;
      assign w_lane = r_req_addr[LSB +: $clog2(LANES)];
      assign w_inst = RamReadData[w_lane*INST_W +: INST_W];
    end else begin : g_one
      assign w_inst = RamReadData[INST_W-1:0];
    end
  endgenerate
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_pc <= RESET_PC;
      r_req_addr <= RESET_PC;
      r_inflight <= 1'b0;
      r_halt <= 1'b0;
    end else begin
      r_inflight <= RamReadEnable;
      r_req_addr <= r_pc;
      if (redirect_valid) begin
        r_pc <= redirect_pc;
        r_halt <= |redirect_pc[1:0];
      end else if (RamReadEnable) r_pc <= r_pc + ADDR_W'(INST_W/8);
    end
  zc_sync_fifo #(.W(ADDR_W + INST_W), .DEPTH(BUF_DEPTH)) u_buf (
    .clk(clk),
    .rst(rst),
    .i_push(w_push),
    .i_data({r_req_addr, w_inst}),
    .i_pop(w_pop),
    .i_clear(redirect_valid),
    .o_data({inst_pc, inst_data}),
    .o_count(w_count),
    .o_full(w_full),
    .o_empty(w_empty)
  );
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(w_push && w_full && !w_pop));
endmodule

// File: tb/tb_zc_fetch_unit.sv
// tb_zc_fetch_unit: directed timing checks plus randomized stream checked against an instruction-order model
module tb_zc_fetch_unit;
  localparam logic [63:0] RST_PC = 64'h8000_0000;
  logic clk = 0, rst = 0;
  logic ram_en, redirect_valid, inst_valid, inst_ready, fetch_misaligned;
  logic [63:0] ram_addr, ram_data, redirect_pc, inst_pc;
  logic [31:0] inst_data;
  int n_tests = 0, n_fail = 0, n_acc = 0;
  logic [63:0] exp_pc = RST_PC, hold_pc;
  logic [31:0] hold_data;
  logic exp_halt = 0, hold = 0;
  always #5 clk = ~clk;
  zc_fetch_unit dut (
    .clk(clk), .rst(rst), .RamReadEnable(ram_en), .RamReadAddr(ram_addr), .RamReadData(ram_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc), .fetch_misaligned(fetch_misaligned)
  );
  function automatic logic [31:0] f(input logic [63:0] x);
    return x[31:0] ^ x[63:32] ^ 32'h5A5A_C3C3;
  endfunction
  function automatic logic [63:0] ram_word(input logic [63:0] a);
    logic [63:0] b;
    b = a & ~64'h7;
    return {f(b + 64'd4), f(b)};
  endfunction
  always @(posedge clk) ram_data <= ram_en ? ram_word(ram_addr) : {$urandom, $urandom};
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask
  // decode-side view: accepted instructions must follow the program order implied by the last restart point
  always @(negedge clk) begin
    if (!rst) begin
      exp_pc = RST_PC;
      exp_halt = 0;
      hold = 0;
    end else begin
      chk("misaligned", fetch_misaligned, exp_halt);
      if (hold) begin
        chk("hold_pc", inst_pc, hold_pc);
        chk("hold_data", inst_data, hold_data);
      end
      if (exp_halt) begin
        chk("halt_en", ram_en, 0);
        chk("halt_valid", inst_valid, 0);
      end
      if (redirect_valid) begin
        exp_pc = redirect_pc;
        exp_halt = |redirect_pc[1:0];
        hold = 0;
      end else begin
        if (inst_valid && inst_ready) begin
          chk("acc_pc", inst_pc, exp_pc);
          chk("acc_data", inst_data, f(exp_pc));
          exp_pc = exp_pc + 64'd4;
          n_acc++;
        end
        hold = inst_valid & !inst_ready;
        hold_pc = inst_pc;
        hold_data = inst_data;
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_reset_vals();
    chk("rst_en", ram_en, 0);
    chk("rst_addr", ram_addr, RST_PC);
    chk("rst_valid", inst_valid, 0);
    chk("rst_data", inst_data, 0);
    chk("rst_pc", inst_pc, 0);
    chk("rst_mis", fetch_misaligned, 0);
  endtask
  task automatic release_rst();
    inst_ready = 1;
    rst = 1;
    #2;
    chk("rel_en", ram_en, 1);
    chk("rel_addr", ram_addr, RST_PC);
    chk("rel_valid", inst_valid, 0);
    cyc(); #2;
    chk("c1_valid", inst_valid, 0);
    cyc(); #2;
    chk("c2_valid", inst_valid, 1);
    chk("c2_pc", inst_pc, RST_PC);
    cyc(); #2;
    chk("c3_pc", inst_pc, RST_PC + 64'd4);
  endtask
  task automatic do_redirect(input logic [63:0] pc);
    redirect_valid = 1;
    redirect_pc = pc;
    cyc();
    redirect_valid = 0;
    #2;
    chk("rd_valid", inst_valid, 0);
    chk("rd_mis", fetch_misaligned, {63'd0, |pc[1:0]});
    if (pc[1:0] != 2'b00) chk("rd_en_halt", ram_en, 0);
    else begin
      chk("rd_en", ram_en, 1);
      chk("rd_addr", ram_addr, pc);
      cyc(); #2;
      chk("rd_v2", inst_valid, 0);
      cyc(); #2;
      chk("rd_v3", inst_valid, 1);
      chk("rd_pc", inst_pc, pc);
    end
  endtask
  initial begin
    inst_ready = 1;
    redirect_valid = 0;
    redirect_pc = 0;
    #12;
    chk_reset_vals();
    cyc();
    release_rst();
    repeat (6) cyc();
    inst_ready = 0;
    repeat (10) cyc();
    #2;
    chk("stall_en", ram_en, 0);
    chk("stall_valid", inst_valid, 1);
    chk("stall_addr", ram_addr, inst_pc + 64'd16);
    inst_ready = 1;
    repeat (8) cyc();
    inst_ready = 0;
    repeat (2) cyc();
    do_redirect(64'h8000_0100);
    inst_ready = 1;
    repeat (5) cyc();
    do_redirect(64'h8000_0102);
    repeat (5) cyc();
    do_redirect(64'h8000_0200);
    repeat (6) cyc();
    inst_ready = 0;
    repeat (2) cyc();
    rst = 0;
    #1;
    chk_reset_vals();
    cyc();
    release_rst();
    repeat (4) cyc();
    do_redirect(64'hFFFF_FFFF_FFFF_FFF8);
    cyc(); #2;
    chk("wrap_fc", inst_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    cyc(); #2;
    chk("wrap_0", inst_pc, 64'h0);
    for (int i = 0; i < 3000; i++) begin
      int r;
      inst_ready = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 99);
      if (r == 0) do_redirect({$urandom, $urandom} & ~64'h3);
      else if (r == 1) do_redirect(RST_PC + 64'({$urandom_range(1, 3)}));
      else cyc();
    end
    inst_ready = 1;
    do_redirect(64'h8000_0400);
    repeat (4) cyc();
    chk("progress", {63'd0, n_acc > 500}, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
